controller_fetch: RTL and testbench
===================================

# controller_fetch

Serial game-controller reader that consumes the GPU's once-per-frame `controller_start_fetch` window and fetches two NES-style shift-register controllers. It produces the latch and clock strobes, samples both serial data lines, and commits the decoded button bytes atomically. The committed bytes are presented to the CPU bus through a tri-stated `data_out`, decoded alongside the VRAM and vblank registers. It runs entirely in the 12.5875 MHz video clock domain.

## Interface
Parameters:
- `HALF_PERIOD`, default 38: length of one strobe half-period in clk cycles (38 ≈ 3.0 µs). Legal range 2..255.

Ports:
- `clk_12_5875`  in  1  video pixel clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `controller_start_fetch`  in  1  fetch request window from the GPU. It is high for several cycles once per frame.
- `ctrl_latch`  out  1  parallel-load strobe to both controllers.
- `ctrl_clk`  out  1  shift clock to both controllers. Idles low.
- `ctrl_data_1`, `ctrl_data_2`  in  1  serial data from each controller. Asynchronous, active-low, pulled up when nothing is connected.
- `SELECT_controller_1`, `SELECT_controller_2`  in  1  CPU read selects.
- `data_out`  out  8  CPU read data.
- `busy`  out  1  high while a fetch is in progress.

## Operation
- Both `ctrl_data_*` inputs pass through a 2-FF synchronizer. Every sample below uses the synchronized value.
- A fetch starts only on a rising edge of `controller_start_fetch`:
  - An edge means the current cycle is 1 and the previous registered value is 0.
  - Holding the input high does not retrigger.
  - Edges that arrive while `busy`=1 are ignored.
- The state machine has three states: IDLE → LATCH → SHIFT → IDLE.
  - LATCH: `ctrl_latch`=1 for 2·H cycles, where H = `HALF_PERIOD`. Bit 0 is sampled on the last LATCH cycle.
  - SHIFT: 7 bit periods. Each period drives `ctrl_clk`=1 for H cycles, then `ctrl_clk`=0 for H cycles. The next bit is sampled on the last low cycle.
  - After the 8th sample, the state returns to IDLE and both result bytes are committed in one cycle.
- Shift registers:
  - Each sample is inverted to active-high and shifted in MSB-first.
  - The first bit shifted in (A) ends up in bit 7. Final layout is A, B, Select, Start, Up, Down, Left, Right, bit 7 down to bit 0.
  - A 3-bit bit counter and an 8-bit half-period counter sequence the shifting.
- `controller_1` / `controller_2` hold the committed bytes.
  - They change only on the commit cycle.
  - The CPU never sees a partially shifted byte.
- CPU read path:
  - `data_out` = `controller_1` when `SELECT_controller_1`, else `controller_2` when `SELECT_controller_2`, else 8'bz.
  - When both selects are asserted, controller 1 wins.
  - The path is combinational from the committed registers.
- A disconnected controller reads 8'h00, because the pull-up gives 1 and inverting gives 0.

## Timing
- Cycle 0 is the edge-detect cycle. Events follow at these cycles:
  - `busy`, `ctrl_latch` rise: cycle 1.
  - `ctrl_latch` falls: after cycle 2H.
  - Bit k (k = 0..7) is sampled at cycle 2H·(k+1).
  - `ctrl_clk` is high during cycles 2H(k+1)+1 … 2H(k+1)+H for k = 0..6.
  - Commit: cycle 16H+1. `busy` reads 0 from that cycle.
- With default H = 38: 609 cycles from edge to commit, about 48 µs. This fits well inside line 0 of the frame.
- `ctrl_latch` and `ctrl_clk` are registered outputs, are never high simultaneously, and are glitch-free.
- Reset values (asserted on any cycle, including mid-fetch):
  - State IDLE.
  - `ctrl_latch`=0, `ctrl_clk`=0, `busy`=0.
  - `controller_1`=`controller_2`=8'h00.
  - Shift registers and counters are cleared.
  - The edge-detect register is cleared, so a start input held high through reset release produces a fetch on the first cycle after reset.
- A start edge on the commit cycle is ignored. The next fetch needs a fresh edge.

## Test plan
- Idle after reset:
  - Check: `ctrl_latch`=`ctrl_clk`=`busy`=0 and `data_out`=z with no select.
  - Stimulus: a select with no fetch yet.
  - Expected: reads 8'h00.
- Basic fetch with H=38:
  - Stimulus: controller 1 models A + Right pressed, serial stream 0,1,1,1,1,1,1,0; controller 2 disconnected (constant 1). Pulse start for 32 cycles.
  - Expected: `controller_1`=8'h81 and `controller_2`=8'h00 at cycle 609. `ctrl_latch` is high for exactly 76 cycles. There are exactly 7 `ctrl_clk` pulses of 38 cycles each.
- Atomic commit:
  - Stimulus: CPU reads `controller_1` every cycle during a fetch that changes the value from 8'h81 to 8'h3C.
  - Expected: the value stays 8'h81 through cycle 16H and reads 8'h3C exactly from cycle 16H+1.
- Retrigger and hold:
  - Stimulus: start held high for 2000 cycles, plus a second edge injected at cycle 300.
  - Expected: exactly one fetch and one commit.
- Reset mid-fetch:
  - Stimulus: assert `rst` at cycle 200 (during SHIFT).
  - Expected: next cycle shows strobes 0, `busy`=0, both bytes 8'h00. A subsequent edge runs a full, correct fetch.
- Select priority and minimum H:
  - Stimulus: H=2; both selects asserted.
  - Expected: `data_out`=`controller_1`. The full fetch commits at cycle 33.

Source files
------------

// File: rtl/controller_fetch.sv
// Reads two NES-style serial controllers once per frame and commits both button bytes in a single cycle.
// Latency: 16*HALF_PERIOD+1 cycles from the start edge to the commit; the CPU read path is combinational.
// Backpressure: none. Start edges are dropped while busy and on the commit cycle.
module controller_fetch #(
  parameter int HALF_PERIOD = 38
) (
  input  logic       clk_12_5875,
  input  logic       rst,
  input  logic       controller_start_fetch,
  output logic       ctrl_latch,
  output logic       ctrl_clk,
  input  logic       ctrl_data_1,
  input  logic       ctrl_data_2,
  input  logic       SELECT_controller_1,
  input  logic       SELECT_controller_2,
  output logic [7:0] data_out,
  output logic       busy
);

  localparam logic [7:0] HALF_LAST = 8'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  sync_1;
  logic [1:0]  sync_2;
  logic        start_q;
  logic        start_rise;

  // Half-period counter plus a phase bit: phase 0 is the first half of a
  // 2H window (latch high / clock high), phase 1 the second half.
  logic [7:0]  half_cnt;
  logic [7:0]  half_cnt_nxt;
  logic        phase;
  logic        phase_nxt;
  logic [2:0]  bit_cnt;
  logic [2:0]  bit_cnt_nxt;

  logic [7:0]  shift_1;
  logic [7:0]  shift_1_nxt;
  logic [7:0]  shift_2;
  logic [7:0]  shift_2_nxt;
  logic [7:0]  controller_1;
  logic [7:0]  controller_1_nxt;
  logic [7:0]  controller_2;
  logic [7:0]  controller_2_nxt;

  logic        sample;
  logic        half_end;
  logic        commit_q;
  logic        commit_nxt;
  logic        latch_nxt;
  logic        clk_nxt;
  logic        busy_nxt;

  // Two-flop synchronizers for the asynchronous serial lines; reset to the
  // pulled-up idle level so a disconnected pad reads as "nothing pressed".
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      sync_1  <= 2'b11;
      sync_2  <= 2'b11;
      start_q <= 1'b0;
    end else begin
      sync_1  <= {sync_1[0], ctrl_data_1};
      sync_2  <= {sync_2[0], ctrl_data_2};
      start_q <= controller_start_fetch;
    end
  end

  assign start_rise = controller_start_fetch & ~start_q;
  assign half_end   = (half_cnt == HALF_LAST);

  // State register.
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, sequencing counters, sampling and the registered strobe values.
  always_comb begin
    state_nxt        = state;
    half_cnt_nxt     = half_cnt;
    phase_nxt        = phase;
    bit_cnt_nxt      = bit_cnt;
    shift_1_nxt      = shift_1;
    shift_2_nxt      = shift_2;
    controller_1_nxt = controller_1;
    controller_2_nxt = controller_2;
    sample           = 1'b0;
    commit_nxt       = 1'b0;

    case (state)
      IDLE: begin
        // The commit cycle is still IDLE; commit_q masks an edge landing there.
        if (start_rise && !commit_q) begin
          state_nxt    = LATCH;
          half_cnt_nxt = 8'd0;
          phase_nxt    = 1'b0;
          bit_cnt_nxt  = 3'd0;
        end
      end
      LATCH: begin
        if (half_end) begin
          half_cnt_nxt = 8'd0;
          if (phase) begin
            // Last latch cycle: bit 0 (A) is already on the line.
            sample    = 1'b1;
            state_nxt = SHIFT;
            phase_nxt = 1'b0;
          end else begin
            phase_nxt = 1'b1;
          end
        end else begin
          half_cnt_nxt = half_cnt + 8'd1;
        end
      end
      SHIFT: begin
        if (half_end) begin
          half_cnt_nxt = 8'd0;
          phase_nxt    = ~phase;
          if (phase) begin
            // End of the low half: the next bit has settled since the rising edge.
            sample = 1'b1;
            if (bit_cnt == 3'd6) begin
              state_nxt  = IDLE;
              commit_nxt = 1'b1;
            end else begin
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end
        end else begin
          half_cnt_nxt = half_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (sample) begin
      shift_1_nxt = {shift_1[6:0], ~sync_1[1]};
      shift_2_nxt = {shift_2[6:0], ~sync_2[1]};
    end

    if (commit_nxt) begin
      controller_1_nxt = shift_1_nxt;
      controller_2_nxt = shift_2_nxt;
    end

    latch_nxt = (state_nxt == LATCH);
    clk_nxt   = (state_nxt == SHIFT) && !phase_nxt;
    busy_nxt  = (state_nxt != IDLE);
  end

  // Datapath and strobe registers; strobes come straight from flops so they cannot glitch.
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      half_cnt     <= 8'd0;
      phase        <= 1'b0;
      bit_cnt      <= 3'd0;
      shift_1      <= 8'h00;
      shift_2      <= 8'h00;
      controller_1 <= 8'h00;
      controller_2 <= 8'h00;
      commit_q     <= 1'b0;
      ctrl_latch   <= 1'b0;
      ctrl_clk     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      half_cnt     <= half_cnt_nxt;
      phase        <= phase_nxt;
      bit_cnt      <= bit_cnt_nxt;
      shift_1      <= shift_1_nxt;
      shift_2      <= shift_2_nxt;
      controller_1 <= controller_1_nxt;
      controller_2 <= controller_2_nxt;
      commit_q     <= commit_nxt;
      ctrl_latch   <= latch_nxt;
      ctrl_clk     <= clk_nxt;
      busy         <= busy_nxt;
    end
  end

  // CPU read mux; controller 1 wins when both selects are asserted.
  assign data_out = SELECT_controller_1 ? controller_1 :
                    SELECT_controller_2 ? controller_2 : 8'bz;

endmodule

// File: tb/tb_controller_fetch.sv
module tb_controller_fetch;

  logic clk = 1'b0;
  always #40 clk = ~clk;

  logic rst;

  // Instance A: default H = 38
  logic       a_start, a_latch, a_sclk, a_d1, a_d2, a_sel1, a_sel2, a_busy;
  wire  [7:0] a_dout;
  // Instance B: minimum H = 2
  logic       b_start, b_latch, b_sclk, b_d1, b_d2, b_sel1, b_sel2, b_busy;
  wire  [7:0] b_dout;

  controller_fetch dut_a (
    .clk_12_5875(clk), .rst(rst), .controller_start_fetch(a_start),
    .ctrl_latch(a_latch), .ctrl_clk(a_sclk), .ctrl_data_1(a_d1), .ctrl_data_2(a_d2),
    .SELECT_controller_1(a_sel1), .SELECT_controller_2(a_sel2),
    .data_out(a_dout), .busy(a_busy)
  );

  controller_fetch #(.HALF_PERIOD(2)) dut_b (
    .clk_12_5875(clk), .rst(rst), .controller_start_fetch(b_start),
    .ctrl_latch(b_latch), .ctrl_clk(b_sclk), .ctrl_data_1(b_d1), .ctrl_data_2(b_d2),
    .SELECT_controller_1(b_sel1), .SELECT_controller_2(b_sel2),
    .data_out(b_dout), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Controller models: a 4021-style shift register; button byte is active-high,
  // bit 7 = A, line is active-low, reads 1 after the eighth bit.
  logic [7:0] btn_a1, btn_a2, btn_b1, btn_b2;
  logic       conn_a2, conn_b2;
  int         a_idx = 0;
  int         b_idx = 0;

  function automatic logic serial(input logic [7:0] b, input int idx);
    if (idx > 7 || idx < 0) return 1'b1;
    return ~b[7 - idx];
  endfunction

  always @(posedge a_latch or posedge a_sclk) begin
    if (a_latch) a_idx = 0;
    else         a_idx = a_idx + 1;
  end
  always @(posedge b_latch or posedge b_sclk) begin
    if (b_latch) b_idx = 0;
    else         b_idx = b_idx + 1;
  end

  assign a_d1 = serial(btn_a1, a_idx);
  assign a_d2 = conn_a2 ? serial(btn_a2, a_idx) : 1'b1;
  assign b_d1 = serial(btn_b1, b_idx);
  assign b_d2 = conn_b2 ? serial(btn_b2, b_idx) : 1'b1;

  // Measurements gathered over one fetch of instance A
  int lat_cnt, lat_first, clk_pulses, clk_bad_len, clk_first, overlap;
  int busy_rises, busy_first, busy_fall, changes, first_new, not_old_early;

  // Caller is at a negedge; that cycle becomes cycle 0 (start sampled high there).
  task automatic fetch_a(input int hold, input int inject, input int ncyc,
                         input logic [7:0] old_v, input logic [7:0] new_v);
    int         run;
    logic       pb;
    logic [7:0] pd;
    lat_cnt = 0; lat_first = -1; clk_pulses = 0; clk_bad_len = 0; clk_first = -1;
    overlap = 0; busy_rises = 0; busy_first = -1; busy_fall = -1; changes = 0;
    first_new = -1; not_old_early = 0;
    run = 0; pb = 1'b0; pd = a_dout;
    for (int n = 0; n <= ncyc; n++) begin
      if (n == 0)    a_start = 1'b1;
      if (n == hold) a_start = 1'b0;
      if (inject > 0 && n == inject - 1) a_start = 1'b0;
      if (inject > 0 && n == inject && n < hold) a_start = 1'b1;
      if (a_latch) begin
        lat_cnt++;
        if (lat_first < 0) lat_first = n;
      end
      if (a_sclk) begin
        run++;
        if (clk_first < 0) clk_first = n;
      end else if (run > 0) begin
        clk_pulses++;
        if (run != 38) clk_bad_len++;
        run = 0;
      end
      if (a_latch && a_sclk) overlap++;
      if (a_busy && !pb) begin
        busy_rises++;
        if (busy_first < 0) busy_first = n;
      end
      if (!a_busy && pb) busy_fall = n;
      pb = a_busy;
      if (a_dout !== pd) changes++;
      pd = a_dout;
      if (a_dout === new_v && first_new < 0) first_new = n;
      if (n <= 608 && a_dout !== old_v) not_old_early++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_sel1 = 1'b0; a_sel2 = 1'b0;
    b_start = 1'b0; b_sel1 = 1'b0; b_sel2 = 1'b0;
    btn_a1 = 8'h81; btn_a2 = 8'h00; conn_a2 = 1'b0;
    btn_b1 = 8'hA5; btn_b2 = 8'h3C; conn_b2 = 1'b1;
    repeat (4) @(negedge clk);

    // Idle after reset
    check("rst_latch", a_latch, 1'b0);
    check("rst_clk", a_sclk, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_z", a_dout === 8'bz, 1'b1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", a_busy, 1'b0);
    check("idle_z_b", b_dout === 8'bz, 1'b1);
    a_sel1 = 1'b1;
    #1 check("idle_sel1", a_dout, 8'h00);
    a_sel1 = 1'b0; a_sel2 = 1'b1;
    #1 check("idle_sel2", a_dout, 8'h00);
    a_sel2 = 1'b0; a_sel1 = 1'b1;
    @(negedge clk);

    // Basic fetch: A + Right on pad 1, pad 2 disconnected
    fetch_a(32, 0, 700, 8'h00, 8'h81);
    check("basic_lat_first", 16'(lat_first), 16'd1);
    check("basic_lat_cnt", 16'(lat_cnt), 16'd76);
    check("basic_busy_first", 16'(busy_first), 16'd1);
    check("basic_clk_first", 16'(clk_first), 16'd77);
    check("basic_clk_pulses", 16'(clk_pulses), 16'd7);
    check("basic_clk_len", 16'(clk_bad_len), 16'd0);
    check("basic_overlap", 16'(overlap), 16'd0);
    check("basic_busy_fall", 16'(busy_fall), 16'd609);
    check("basic_commit", 16'(first_new), 16'd609);
    check("basic_early", 16'(not_old_early), 16'd0);
    a_sel1 = 1'b0; a_sel2 = 1'b1;
    #1 check("basic_pad2", a_dout, 8'h00);
    a_sel2 = 1'b0; a_sel1 = 1'b1;
    repeat (5) @(negedge clk);

    // Atomic commit: 8'h81 -> 8'h3C, read every cycle
    btn_a1 = 8'h3C;
    fetch_a(32, 0, 700, 8'h81, 8'h3C);
    check("atomic_early", 16'(not_old_early), 16'd0);
    check("atomic_commit", 16'(first_new), 16'd609);
    check("atomic_changes", 16'(changes), 16'd1);
    repeat (5) @(negedge clk);

    // Start held high 2000 cycles with a second edge at cycle 300
    btn_a1 = 8'h81;
    fetch_a(2000, 300, 2010, 8'h3C, 8'h81);
    check("hold_busy_rises", 16'(busy_rises), 16'd1);
    check("hold_changes", 16'(changes), 16'd1);
    check("hold_commit", 16'(first_new), 16'd609);
    check("hold_busy_end", a_busy, 1'b0);
    repeat (5) @(negedge clk);

    // Reset asserted at cycle 200 (in SHIFT)
    btn_a1 = 8'h5A; btn_a2 = 8'hC3; conn_a2 = 1'b1;
    a_start = 1'b1;
    repeat (5) @(negedge clk);
    a_start = 1'b0;
    repeat (195) @(negedge clk);
    check("mid_busy", a_busy, 1'b1);
    check("mid_shift", a_latch, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_latch", a_latch, 1'b0);
    check("mrst_clk", a_sclk, 1'b0);
    check("mrst_busy", a_busy, 1'b0);
    check("mrst_pad1", a_dout, 8'h00);
    a_sel1 = 1'b0; a_sel2 = 1'b1;
    #1 check("mrst_pad2", a_dout, 8'h00);
    a_sel2 = 1'b0; a_sel1 = 1'b1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    fetch_a(32, 0, 700, 8'h00, 8'h5A);
    check("after_commit", 16'(first_new), 16'd609);
    check("after_lat_cnt", 16'(lat_cnt), 16'd76);
    check("after_clk_pulses", 16'(clk_pulses), 16'd7);
    a_sel1 = 1'b0; a_sel2 = 1'b1;
    #1 check("after_pad2", a_dout, 8'hC3);
    a_sel1 = 1'b1;
    #1 check("after_both", a_dout, 8'h5A);

    // H = 2, both selects, edge on the commit cycle is ignored
    b_sel1 = 1'b1; b_sel2 = 1'b1;
    @(negedge clk);
    b_start = 1'b1;
    for (int n = 0; n <= 40; n++) begin
      if (n == 3)  b_start = 1'b0;
      if (n == 33) b_start = 1'b1;
      if (n == 1)  check("h2_busy1", b_busy, 1'b1);
      if (n == 1)  check("h2_latch1", b_latch, 1'b1);
      if (n == 4)  check("h2_latch4", b_latch, 1'b1);
      if (n == 5)  check("h2_latch5", b_latch, 1'b0);
      if (n == 5)  check("h2_clk5", b_sclk, 1'b1);
      if (n == 7)  check("h2_clk7", b_sclk, 1'b0);
      if (n == 32) check("h2_dout32", b_dout, 8'h00);
      if (n == 32) check("h2_busy32", b_busy, 1'b1);
      if (n == 33) check("h2_dout33", b_dout, 8'hA5);
      if (n == 33) check("h2_busy33", b_busy, 1'b0);
      if (n == 34) check("h2_commit_edge", b_busy, 1'b0);
      if (n == 40) check("h2_still_idle", b_busy, 1'b0);
      @(negedge clk);
    end
    b_sel1 = 1'b0;
    #1 check("h2_pad2", b_dout, 8'h3C);
    b_start = 1'b0;
    btn_b1 = 8'h18;
    repeat (2) @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    check("h2_fresh_busy", b_busy, 1'b1);
    b_start = 1'b0;
    repeat (40) @(negedge clk);
    check("h2_fresh_done", b_busy, 1'b0);
    b_sel1 = 1'b1;
    #1 check("h2_fresh_dout", b_dout, 8'h18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
